// File: rtl/dm_sba_ctrl_pkg.sv
// Shared types and helpers for the debug-module system bus access sequencer.
package dm_sba_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    WAIT_R,
    WAIT_W
  } sba_state_e;

  localparam logic [2:0] SbErrBusError = 3'd2;
  localparam logic [2:0] SbErrAlign    = 3'd3;
  localparam logic [2:0] SbErrSize     = 3'd4;

  // Byte enables for a 2^size-byte access at a byte offset, up to 64-bit buses.
  function automatic logic [7:0] be_gen(
    input logic [2:0] size,
    input logic [2:0] offset
  );
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < (1 << size));
    end
    return m << offset;
  endfunction

endpackage

// File: rtl/dm_sba_ctrl.sv
// System bus access sequencer: turns SBCS/SBADDRESS/SBDATA events into
// single-beat req/gnt/rvalid bus transactions.
module dm_sba_ctrl
  import dm_sba_ctrl_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbautoincrement_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic [2:0]            sberror_i,
  input  logic                  sbbusyerror_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbdata_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth/8-1:0] be_o,
  output logic [BusWidth-1:0]   wdata_o,
  input  logic                  rvalid_i,
  input  logic [BusWidth-1:0]   rdata_i,
  input  logic                  err_i
);

  localparam int NB   = BusWidth / 8;
  localparam int OffW = $clog2(NB);

  sba_state_e          state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusWidth-1:0] data_q, data_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic [2:0]          size_q, size_d;
  logic                discard_q, discard_d;
  logic                data_valid_q, data_valid_d;
  logic                err_valid_q, err_valid_d;
  logic [2:0]          err_q, err_d;
  logic                busyerr_q, busyerr_d;

  logic                any_event;
  logic                trig_ok;
  logic                wr_trig;
  logic                rd_trig;
  logic [BusWidth-1:0] chk_addr;
  logic                size_bad;
  logic                misaligned;
  logic [2:0]          off3;
  logic [7:0]          be_full;
  logic [BusWidth-1:0] wdata_rep;
  logic [BusWidth-1:0] rd_shift;
  logic [BusWidth-1:0] rd_mask;
  logic                resp_now;
  int                  nb_acc;
  int                  nb_size;

  assign any_event = sbaddress_write_valid_i | sbdata_write_valid_i
                   | sbdata_read_valid_i;
  assign trig_ok   = dmactive_i && (sberror_i == 3'd0) && !sbbusyerror_i;
  assign wr_trig   = trig_ok && sbdata_write_valid_i;
  assign rd_trig   = trig_ok
                   && ((sbaddress_write_valid_i && sbreadonaddr_i)
                    || (sbdata_read_valid_i && sbreadondata_i));

  // A same-cycle address write is what the access will actually use.
  assign chk_addr = sbaddress_write_valid_i ? sbaddress_i : addr_q;
  assign size_bad = sbaccess_i > 3'(OffW);

  always_comb begin
    nb_acc     = 1 << sbaccess_i;
    misaligned = 1'b0;
    for (int b = 0; b < OffW; b++) begin
      if ((b < int'(sbaccess_i)) && chk_addr[b]) misaligned = 1'b1;
    end
    off3            = '0;
    off3[OffW-1:0]  = chk_addr[OffW-1:0];
    be_full         = be_gen(sbaccess_i, off3);
    for (int i = 0; i < NB; i++) begin
      wdata_rep[8*i +: 8] = sbdata_i[8*(i % nb_acc) +: 8];
    end
  end

  always_comb begin
    nb_size  = 1 << size_q;
    rd_shift = rdata_i >> {addr_q[OffW-1:0], 3'b000};
    for (int i = 0; i < NB; i++) begin
      rd_mask[8*i +: 8] = (i < nb_size) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    size_d       = size_q;
    discard_d    = discard_q;
    data_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    err_d        = err_q;
    busyerr_d    = 1'b0;
    resp_now     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!dmactive_i) begin
          addr_d = '0;
        end else begin
          if (sbaddress_write_valid_i) addr_d = sbaddress_i;
          if (wr_trig || rd_trig) begin
            if (size_bad) begin
              err_valid_d = 1'b1;
              err_d       = SbErrSize;
            end else if (misaligned) begin
              err_valid_d = 1'b1;
              err_d       = SbErrAlign;
            end else begin
              size_d  = sbaccess_i;
              be_d    = be_full[NB-1:0];
              state_d = wr_trig ? WRITE : READ;
              if (wr_trig) wdata_d = wdata_rep;
            end
          end
        end
      end
      READ, WRITE: begin
        if (!dmactive_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          busyerr_d = any_event;
          if (gnt_i) begin
            if (rvalid_i) resp_now = 1'b1;
            else state_d = (state_q == READ) ? WAIT_R : WAIT_W;
          end
        end
      end
      WAIT_R, WAIT_W: begin
        busyerr_d = dmactive_i && any_event;
        if (!dmactive_i) discard_d = 1'b1;
        if (rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          resp_now  = dmactive_i && !discard_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resp_now) begin
      state_d = IDLE;
      if (err_i) begin
        err_valid_d = 1'b1;
        err_d       = SbErrBusError;
      end else begin
        if (state_q == READ || state_q == WAIT_R) begin
          data_d       = rd_shift & rd_mask;
          data_valid_d = 1'b1;
        end
        if (sbautoincrement_i) begin
          addr_d = addr_q + (BusWidth'(1) << size_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      size_q       <= '0;
      discard_q    <= 1'b0;
      data_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_q        <= '0;
      busyerr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      size_q       <= size_d;
      discard_q    <= discard_d;
      data_valid_q <= data_valid_d;
      err_valid_q  <= err_valid_d;
      err_q        <= err_d;
      busyerr_q    <= busyerr_d;
    end
  end

  assign sbaddress_o     = addr_q;
  assign sbdata_o        = data_q;
  assign sbdata_valid_o  = data_valid_q;
  assign sbbusy_o        = (state_q != IDLE);
  assign sbbusyerror_o   = busyerr_q;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;
  assign req_o           = (state_q == READ) || (state_q == WRITE);
  assign we_o            = (state_q == WRITE);
  assign addr_o          = addr_q;
  assign be_o            = be_q;
  assign wdata_o         = wdata_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Directed bench for dm_sba_ctrl at BusWidth 32.
module tb_dm_sba_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        dmactive_i;
  logic [2:0]  sbaccess_i;
  logic        sbautoincrement_i;
  logic        sbreadonaddr_i;
  logic        sbreadondata_i;
  logic [2:0]  sberror_i;
  logic        sbbusyerror_i;
  logic        sbaddress_write_valid_i;
  logic [31:0] sbaddress_i;
  logic        sbdata_write_valid_i;
  logic [31:0] sbdata_i;
  logic        sbdata_read_valid_i;
  logic [31:0] sbaddress_o;
  logic [31:0] sbdata_o;
  logic        sbdata_valid_o;
  logic        sbbusy_o;
  logic        sbbusyerror_o;
  logic        sberror_valid_o;
  logic [2:0]  sberror_o;
  logic        req_o;
  logic        gnt_i;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  int checks = 0;
  int errors = 0;

  dm_sba_ctrl #(.BusWidth(32)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_ni),
    .dmactive_i              (dmactive_i),
    .sbaccess_i              (sbaccess_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbreadondata_i          (sbreadondata_i),
    .sberror_i               (sberror_i),
    .sbbusyerror_i           (sbbusyerror_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbaddress_i             (sbaddress_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbdata_i                (sbdata_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbaddress_o             (sbaddress_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sbbusyerror_o           (sbbusyerror_o),
    .sberror_valid_o         (sberror_valid_o),
    .sberror_o               (sberror_o),
    .req_o                   (req_o),
    .gnt_i                   (gnt_i),
    .we_o                    (we_o),
    .addr_o                  (addr_o),
    .be_o                    (be_o),
    .wdata_o                 (wdata_o),
    .rvalid_i                (rvalid_i),
    .rdata_i                 (rdata_i),
    .err_i                   (err_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  exp_be [4];
  logic [31:0] exp_wd [4];

  initial begin
    exp_be[0] = 4'h8; exp_be[1] = 4'h1;
    exp_be[2] = 4'h2; exp_be[3] = 4'h4;
    exp_wd[0] = 32'h11111111; exp_wd[1] = 32'h22222222;
    exp_wd[2] = 32'h33333333; exp_wd[3] = 32'h44444444;

    rst_ni = 1'b0; dmactive_i = 1'b1; sbaccess_i = 3'd2;
    sbautoincrement_i = 1'b0; sbreadonaddr_i = 1'b0;
    sbreadondata_i = 1'b0; sberror_i = 3'd0; sbbusyerror_i = 1'b0;
    sbaddress_write_valid_i = 1'b0; sbaddress_i = '0;
    sbdata_write_valid_i = 1'b0; sbdata_i = '0;
    sbdata_read_valid_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    rdata_i = '0; err_i = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(sbbusy_o), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_addr", sbaddress_o, 32'h0);
    chk("rst_data", sbdata_o, 32'h0);
    chk("rst_errv", 32'(sberror_valid_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 1: word read on address write
    sbreadonaddr_i = 1'b1; sbaddress_i = 32'h1000;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    chk("t1_req", 32'(req_o), 32'd1);
    chk("t1_we", 32'(we_o), 32'd0);
    chk("t1_addr", addr_o, 32'h1000);
    chk("t1_be", 32'(be_o), 32'hF);
    chk("t1_busy", 32'(sbbusy_o), 32'd1);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    chk("t1_req_drop", 32'(req_o), 32'd0);
    chk("t1_busy_w", 32'(sbbusy_o), 32'd1);
    rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF;
    tick();
    rvalid_i = 1'b0;
    chk("t1_data", sbdata_o, 32'hDEADBEEF);
    chk("t1_dvalid", 32'(sbdata_valid_o), 32'd1);
    chk("t1_idle", 32'(sbbusy_o), 32'd0);
    tick();
    chk("t1_dvalid_once", 32'(sbdata_valid_o), 32'd0);

    // 2: byte writes with autoincrement
    sbreadonaddr_i = 1'b0; sbaccess_i = 3'd0; sbautoincrement_i = 1'b1;
    sbaddress_i = 32'h3; sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sbdata_i = 32'h11 * (k + 1); sbdata_write_valid_i = 1'b1;
      tick();
      sbdata_write_valid_i = 1'b0;
      chk("t2_req", 32'(req_o), 32'd1);
      chk("t2_we", 32'(we_o), 32'd1);
      chk("t2_addr", addr_o, 32'h3 + k);
      chk("t2_be", 32'(be_o), 32'(exp_be[k]));
      chk("t2_wdata", wdata_o, exp_wd[k]);
      gnt_i = 1'b1; rvalid_i = 1'b1;
      tick();
      gnt_i = 1'b0; rvalid_i = 1'b0;
      chk("t2_idle", 32'(sbbusy_o), 32'd0);
    end
    chk("t2_final_addr", sbaddress_o, 32'h7);

    // 3: alignment and size errors
    sbautoincrement_i = 1'b0; sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1;
    sbaddress_i = 32'h1002; sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    chk("t3_align_v", 32'(sberror_valid_o), 32'd1);
    chk("t3_align", 32'(sberror_o), 32'd3);
    chk("t3_align_req", 32'(req_o), 32'd0);
    chk("t3_align_busy", 32'(sbbusy_o), 32'd0);
    chk("t3_addr_load", sbaddress_o, 32'h1002);
    sbaccess_i = 3'd3; sbaddress_i = 32'h1000;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    chk("t3_size_v", 32'(sberror_valid_o), 32'd1);
    chk("t3_size", 32'(sberror_o), 32'd4);
    chk("t3_size_req", 32'(req_o), 32'd0);
    tick();
    chk("t3_errv_once", 32'(sberror_valid_o), 32'd0);

    // 4: bus error on read, then a halfword read at offset 2
    sbaccess_i = 3'd2; sbautoincrement_i = 1'b1;
    sbaddress_i = 32'h2000; sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    gnt_i = 1'b1; rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'h12345678;
    tick();
    gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0;
    chk("t4_errv", 32'(sberror_valid_o), 32'd1);
    chk("t4_err", 32'(sberror_o), 32'd2);
    chk("t4_data_keep", sbdata_o, 32'hDEADBEEF);
    chk("t4_no_dvalid", 32'(sbdata_valid_o), 32'd0);
    chk("t4_no_inc", sbaddress_o, 32'h2000);
    sbaccess_i = 3'd1; sbaddress_i = 32'h2002;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    chk("t4_hw_be", 32'(be_o), 32'hC);
    gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hABCD1234;
    tick();
    gnt_i = 1'b0; rvalid_i = 1'b0;
    chk("t4_hw_data", sbdata_o, 32'h0000ABCD);
    chk("t4_hw_inc", sbaddress_o, 32'h2004);

    // 5: busy error during an in-flight write
    sbautoincrement_i = 1'b0; sbreadonaddr_i = 1'b0; sbaccess_i = 3'd2;
    sbdata_i = 32'hCAFEF00D; sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    chk("t5_wdata", wdata_o, 32'hCAFEF00D);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    sbdata_i = 32'h55555555; sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    chk("t5_busyerr", 32'(sbbusyerror_o), 32'd1);
    chk("t5_wdata_keep", wdata_o, 32'hCAFEF00D);
    chk("t5_busy", 32'(sbbusy_o), 32'd1);
    rvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    chk("t5_idle", 32'(sbbusy_o), 32'd0);
    chk("t5_busyerr_once", 32'(sbbusyerror_o), 32'd0);
    sbbusyerror_i = 1'b1; sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    chk("t5_blocked_req", 32'(req_o), 32'd0);
    chk("t5_blocked_busy", 32'(sbbusy_o), 32'd0);
    sbbusyerror_i = 1'b0;

    // 6: dmactive drop before grant and while waiting
    sbreadonaddr_i = 1'b1; sbaddress_i = 32'h3000;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    chk("t6_req", 32'(req_o), 32'd1);
    dmactive_i = 1'b0;
    tick();
    chk("t6_req_drop", 32'(req_o), 32'd0);
    chk("t6_idle", 32'(sbbusy_o), 32'd0);
    chk("t6_addr_clr", sbaddress_o, 32'h0);
    dmactive_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    dmactive_i = 1'b0;
    tick();
    chk("t6_wait_busy", 32'(sbbusy_o), 32'd1);
    rvalid_i = 1'b1; rdata_i = 32'h99999999;
    tick();
    rvalid_i = 1'b0;
    chk("t6_no_dvalid", 32'(sbdata_valid_o), 32'd0);
    chk("t6_data_keep", sbdata_o, 32'h0000ABCD);
    chk("t6_end_idle", 32'(sbbusy_o), 32'd0);
    dmactive_i = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
